fp_div_iter: RTL and testbench

Parametrised, multi-cycle IEEE-754-style floating-point divider that computes a/b one quotient bit per clock using restoring division. It supersedes the single-cycle combinational divide path for designs that need a configurable exponent/fraction width and flow control. It adds valid/ready handshaking, fixed latency, and special-operand handling (zero, infinity, NaN, divide-by-zero). It sits between the operand-issue logic and the result writeback in the FPU datapath.

---
 rtl/fp_div_iter.sv | 155 +++++++++++++++
 tb/tb_fp_div_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754-style divider: restoring division, one quotient bit per clock,
// valid/ready handshaking, fixed latency and special-operand handling.
module fp_div_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+FRAC_W:0]       a,
  input  logic [EXP_W+FRAC_W:0]       b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+FRAC_W:0]       result,
  output logic                        overflag,
  output logic                        underflag,
  output logic                        dz_flag,
  output logic                        nan_flag
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int N  = FRAC_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   sign;
  logic signed [EW-1:0]   e;
  logic [FRAC_W+1:0]      rem;
  logic [FRAC_W:0]        dvs;
  logic [N-1:0]           q;
  logic [FRAC_W-1:0]      nfrac;
  logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic [EXP_W-1:0]       ea, eb;
  logic [FRAC_W-1:0]      fa, fb;
  logic                   ge;
  logic [FRAC_W+1:0]      rem_sel;

  always_comb begin
    ea      = a[FRAC_W +: EXP_W];
    eb      = b[FRAC_W +: EXP_W];
    fa      = a[FRAC_W-1:0];
    fb      = b[FRAC_W-1:0];
    ge      = (rem >= {1'b0, dvs});
    rem_sel = ge ? (rem - {1'b0, dvs}) : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sign      <= 1'b0;
      e         <= '0;
      rem       <= '0;
      dvs       <= '0;
      q         <= '0;
      nfrac     <= '0;
      a_zero    <= 1'b0;
      a_inf     <= 1'b0;
      a_nan     <= 1'b0;
      b_zero    <= 1'b0;
      b_inf     <= 1'b0;
      b_nan     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflag  <= 1'b0;
      underflag <= 1'b0;
      dz_flag   <= 1'b0;
      nan_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign      <= a[W-1] ^ b[W-1];
            e         <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
            rem       <= {2'b01, fa};
            dvs       <= {1'b1, fb};
            q         <= '0;
            cnt       <= '0;
            a_zero    <= (ea == '0);
            a_inf     <= (ea == '1) && (fa == '0);
            a_nan     <= (ea == '1) && (fa != '0);
            b_zero    <= (eb == '0);
            b_inf     <= (eb == '1) && (fb == '0);
            b_nan     <= (eb == '1) && (fb != '0);
            in_ready  <= 1'b0;
            result    <= '0;
            overflag  <= 1'b0;
            underflag <= 1'b0;
            dz_flag   <= 1'b0;
            nan_flag  <= 1'b0;
            state     <= S_DIV;
          end
        end
        S_DIV: begin
          q   <= {q[N-2:0], ge};
          // rem_sel < dvs < 2^(FRAC_W+1), so the shift never loses a bit
          rem <= {rem_sel[FRAC_W:0], 1'b0};
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= S_NORM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NORM: begin
          if (q[N-1]) begin
            nfrac <= q[N-2:1];
          end else begin
            nfrac <= q[N-3:0];
            e     <= e - EW'(1);
          end
          state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle registers the final result; afterwards it is held until accepted
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
              result   <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
              nan_flag <= 1'b1;
            end else if (b_zero && !a_inf) begin
              result  <= {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              dz_flag <= 1'b1;
            end else if (a_inf || b_zero) begin
              result <= {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else if (a_zero || b_inf) begin
              result <= {sign, {(W-1){1'b0}}};
            end else if (e >= E_MAX) begin
              result   <= {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              overflag <= 1'b1;
            end else if (e <= 0) begin
              result    <= {sign, {(W-1){1'b0}}};
              underflag <= 1'b1;
            end else begin
              result <= {sign, e[EXP_W-1:0], nfrac};
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter (single precision plus a half-precision build).
module tb_fp_div_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflag, underflag, dz_flag, nan_flag;

  logic        h_in_valid, h_in_ready, h_out_valid;
  logic [15:0] h_a, h_b, h_result;
  logic        h_over, h_under, h_dz, h_nan;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflag(overflag), .underflag(underflag),
    .dz_flag(dz_flag), .nan_flag(nan_flag)
  );

  fp_div_iter #(.EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(1'b1),
    .result(h_result), .overflag(h_over), .underflag(h_under),
    .dz_flag(h_dz), .nan_flag(h_nan)
  );

  // Issues one operation and waits (bounded) for the result; out_ready decides the exit
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output logic [3:0] fl, output int cyc);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
    fl  = {overflag, underflag, dz_flag, nan_flag};
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 ||
        {overflag, underflag, dz_flag, nan_flag} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h f=%b want v=0 r=00000000 f=0000",
               out_valid, result, {overflag, underflag, dz_flag, nan_flag});
    end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] f; int c;
    out_ready = 1'b1;
    do_op(32'h40C00000, 32'h40000000, r, f, c);
    checks++;
    if (r !== 32'h40400000 || f !== 4'b0000) begin
      errors++; $display("FAIL basic_6_div_2: got %h f=%b want 40400000 f=0000", r, f);
    end
    checks++;
    if (c !== 27) begin
      errors++; $display("FAIL basic_latency: got %0d want 27", c);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_hs: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_r;
    logic [3:0]  exp_f; // {over, under, dz, nan}
  } vec_t;

  task automatic test_vectors();
    vec_t v[7];
    logic [31:0] r; logic [3:0] f; int c;
    v[0] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000};
    v[1] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000};
    v[2] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b1000};
    v[3] = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0100};
    v[4] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010};
    v[5] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001};
    v[6] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].av, v[i].bv, r, f, c);
      checks++;
      if (r !== v[i].exp_r || f !== v[i].exp_f || c !== 27) begin
        errors++;
        $display("FAIL vec%0d %h/%h: got %h f=%b lat=%0d want %h f=%b lat=27",
                 i, v[i].av, v[i].bv, r, f, c, v[i].exp_r, v[i].exp_f);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    int c; int extra; bit busy_ok; bit hold_ok;
    out_ready = 1'b0;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0; busy_ok = 1'b1;
    while (!out_valid && c < 200) begin
      if (c == 3) begin a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (c !== 27 || !busy_ok) begin
      errors++; $display("FAIL hold_busy: got lat=%0d busy_ok=%b want lat=27 busy_ok=1", c, busy_ok);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0 ||
          {overflag, underflag, dz_flag, nan_flag} !== 4'b0) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!hold_ok || result !== 32'h40400000) begin
      errors++; $display("FAIL hold_stable: got ok=%b r=%h want ok=1 r=40400000", hold_ok, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL single_result: got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [3:0] f; int c;
    out_ready = 1'b1;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        {overflag, underflag, dz_flag, nan_flag} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b v=%b r=%h want rdy=1 v=0 r=00000000",
               in_ready, out_valid, result);
    end
    #5 rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) c++;
    end
    checks++;
    if (c !== 0) begin
      errors++; $display("FAIL reset_abort: got %0d valid cycles want 0", c);
    end
    do_op(32'h40C00000, 32'h40000000, r, f, c);
    checks++;
    if (r !== 32'h40400000 || f !== 4'b0 || c !== 27) begin
      errors++; $display("FAIL reset_recover: got %h f=%b lat=%0d want 40400000 f=0000 lat=27", r, f, c);
    end
  endtask

  task automatic test_half();
    int c;
    h_a = 16'h4600; h_b = 16'h4000; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    c = 0;
    while (!h_out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (h_result !== 16'h4200 || {h_over, h_under, h_dz, h_nan} !== 4'b0) begin
      errors++; $display("FAIL half_6_div_2: got %h want 4200", h_result);
    end
    checks++;
    if (c !== 14) begin
      errors++; $display("FAIL half_latency: got %0d want 14", c);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    h_in_valid = 1'b0; h_a = '0; h_b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_vectors();
    test_back_to_back_hold();
    test_reset_mid();
    test_half();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
